disp_scan_ctrl: RTL and testbench

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

---
 rtl/disp_pkg.sv | 22 ++
 rtl/bin2bcd_seq.sv | 58 +++++
 rtl/disp_scan_ctrl.sv | 113 +++++++++++
 tb/tb_disp_scan_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants, controller state type and BCD helper for the display scan block.
package disp_pkg;

    localparam int unsigned BIN_W      = 14;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
    localparam int unsigned MAX_VAL    = 9999;
    localparam int unsigned ITER_W     = $clog2(BIN_W);
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } ctrl_state_e;

    // Double-dabble correction: a nibble of 5 or more would carry wrongly after the shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one adjust-and-shift step per shift_i cycle.
module bin2bcd_seq
    import disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             shift_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic [BCD_W-1:0] bcd_o,
    output logic             last_o
);

    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [BCD_W-1:0]  adj;
    logic [BCD_W+BIN_W-1:0] shifted;

    // Next-state: capture on start, otherwise adjust every BCD nibble then shift the whole chain left.
    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            adj[i*4 +: 4] = dd_adjust(bcd_q[i*4 +: 4]);
        end
        shifted = {adj, bin_q} << 1;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        if (start_i) begin
            bin_d  = bin_i;
            bcd_d  = '0;
            iter_d = '0;
        end else if (shift_i) begin
            bin_d  = shifted[BIN_W-1:0];
            bcd_d  = shifted[BCD_W+BIN_W-1:BIN_W];
            iter_d = iter_q + 1'b1;
        end
    end

    // Shift register and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            iter_q <= iter_d;
        end
    end

    assign bcd_o  = bcd_q;
    // High during the final shift, so the result is complete on the following cycle.
    assign last_o = (iter_q == ITER_W'(BIN_W - 1));

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 4-digit display: load controller, BCD conversion and free-running digit scan.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             load,
    output logic             busy,
    output logic             overflow,
    output logic [3:0]       digit,
    output logic [3:0]       an,
    output logic             blank
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    ctrl_state_e state_q, state_d;
    logic                        ovf_q, ovf_d;
    logic [NUM_DIGITS-1:0][3:0]  disp_q, disp_d;
    logic [PW-1:0]               pre_q, pre_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        start, shift, last;
    logic [BCD_W-1:0]            bcd;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .shift_i (shift),
        .bin_i   (bin_in),
        .bcd_o   (bcd),
        .last_o  (last)
    );

    // Controller next-state: accept in-range loads only when idle, commit result after the last shift.
    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        start   = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    if (bin_in > BIN_W'(MAX_VAL)) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d   = 1'b0;
                        start   = 1'b1;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                shift = 1'b1;
                if (last) state_d = COMMIT;
            end
            COMMIT: begin
                disp_d  = bcd;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan next-state: prescaler wraps at PRESCALE-1 and advances the slot index.
    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PW'(PRESCALE - 1)) begin
            pre_d = '0;
            idx_d = idx_q + 1'b1;
        end
    end

    // State, display and scan registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
            pre_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
        end
    end

    // Output mux with leading-zero blanking: slot i>0 is dark when digits i..top are all zero.
    always_comb begin
        blank = (idx_q != '0);
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if (j >= 32'(idx_q) && disp_q[j[IDX_W-1:0]] != 4'd0) blank = 1'b0;
        end
        an    = '1;
        digit = '0;
        if (!blank) begin
            an[idx_q] = 1'b0;
            digit     = disp_q[idx_q];
        end
    end

    assign busy     = (state_q != IDLE);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench: reference model queues accepted loads, monitor pops on busy fall and checks the scan.
module tb_disp_scan_ctrl;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [13:0] bin_in = '0;
    logic        busy, overflow, blank;
    logic [3:0]  digit, an;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.PRESCALE(P)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bin_in   (bin_in),
        .load     (load),
        .busy     (busy),
        .overflow (overflow),
        .digit    (digit),
        .an       (an),
        .blank    (blank)
    );

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: cycle count since reset, busy window length, overflow flag, accepted values.
    int n = 0;
    int busy_cnt = 0;
    bit m_ovf = 1'b0;
    int exp_q[$];
    int shown = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            busy_cnt = 0;
            m_ovf = 1'b0;
            exp_q.delete();
        end else begin
            n++;
            if (busy_cnt > 0) begin
                busy_cnt--;
            end else if (load) begin
                if (int'(bin_in) > 9999) begin
                    m_ovf = 1'b1;
                end else begin
                    m_ovf = 1'b0;
                    exp_q.push_back(int'(bin_in));
                    busy_cnt = 15;
                end
            end
        end
    end

    // Monitor: compare status every cycle, take the next expected value when busy falls, check the active slot.
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        int idx, p10, e_blank, e_digit, e_an;
        if (!rst_n) begin
            prev_busy = 1'b0;
            shown = 0;
        end else begin
            check("busy", busy, busy_cnt > 0);
            check("overflow", overflow, m_ovf);
            if (prev_busy && !busy) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL commit: got unexpected commit expected none pending (t=%0t)", $time);
                end else begin
                    shown = exp_q.pop_front();
                end
            end
            prev_busy = busy;
            idx     = (n / P) % 4;
            p10     = 10 ** idx;
            e_blank = (idx > 0 && shown < p10) ? 1 : 0;
            e_digit = e_blank ? 0 : (shown / p10) % 10;
            e_an    = e_blank ? 15 : (15 & ~(1 << idx));
            check("digit", digit, e_digit);
            check("an", an, e_an);
            check("blank", blank, e_blank);
        end
    end

    task automatic pulse_load(input int v);
        @(negedge clk);
        load = 1'b1;
        bin_in = 14'(v);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || busy_cnt > 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", k < 100, 1);
    endtask

    task automatic scan_full();
        repeat (4 * P + 2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int v;
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_an", an, 4'b1110);
        check("rst_digit", digit, 0);
        check("rst_blank", blank, 0);
        #1 rst_n = 1'b1;
        scan_full();

        // Conversion of 1234 with exact busy length
        pulse_load(1234);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_len", cnt, 15);
        scan_full();

        // Blanking
        pulse_load(7);   wait_idle(); scan_full();
        pulse_load(0);   wait_idle(); scan_full();

        // Bounds
        pulse_load(9999); wait_idle(); scan_full();
        pulse_load(10000);
        repeat (3) begin
            check("ovf_no_busy", busy, 0);
            @(negedge clk);
        end
        check("ovf_set", overflow, 1);
        scan_full();

        // Handshake: second load on the 5th busy cycle is ignored
        pulse_load(1234);
        repeat (3) @(negedge clk);
        pulse_load(5678);
        wait_idle(); scan_full();
        pulse_load(16383); scan_full();
        pulse_load(5678); wait_idle();
        check("ovf_cleared", overflow, 0);
        scan_full();

        // Randomized loads, some landing while busy
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(10000, 16383);
                1:       v = $urandom_range(0, 99);
                default: v = $urandom_range(0, 9999);
            endcase
            pulse_load(v);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        wait_idle(); scan_full();

        // Reset in the middle of a conversion
        pulse_load(1234);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_an", an, 4'b1110);
        check("midrst_digit", digit, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        scan_full();
        scan_full();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
